// File: rtl/mu0_regfile.sv
// MU0 register bank: 2^ADDR_W x WIDTH, one hold/load/inc/clr write port, two read ports.
// Define MU0_REGFILE_BYPASS_EN to forward the pending write onto QA/QB.
module mu0_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ADDR_W = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [1:0]        Op,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] RAddrA,
  input  logic [ADDR_W-1:0] RAddrB,
  output logic [WIDTH-1:0]  QA,
  output logic [WIDTH-1:0]  QB,
  output logic              Wrap
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] wdata;
  logic             wr;
  logic             wrap_nx;

  always_comb begin
    cur     = regs[WAddr];
    wdata   = cur;
    wr      = 1'b0;
    wrap_nx = 1'b0;
    if (En) begin
      unique case (op_e'(Op))
        OP_HOLD: wr = 1'b0;
        OP_LOAD: begin
          wr    = 1'b1;
          wdata = D;
        end
        OP_INC: begin
          wr      = 1'b1;
          wdata   = cur + WIDTH'(1);
          wrap_nx = &cur;
        end
        OP_CLR: begin
          wr    = 1'b1;
          wdata = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      Wrap <= 1'b0;
    end else begin
      if (wr) regs[WAddr] <= wdata;
      Wrap <= wrap_nx;
    end
  end

`ifdef MU0_REGFILE_BYPASS_EN
  logic fwd;
  assign fwd = Reset && wr;
  assign QA = (fwd && RAddrA == WAddr) ? wdata : regs[RAddrA];
  assign QB = (fwd && RAddrB == WAddr) ? wdata : regs[RAddrB];
`else
  assign QA = regs[RAddrA];
  assign QB = regs[RAddrB];
`endif

endmodule

// File: tb/tb_mu0_regfile.sv
// Bench for mu0_regfile: directed plan then random ops vs an array model.
// Two instances cover RESET_VAL = 0 and RESET_VAL = 16'h0100.
module tb_mu0_regfile;

  logic        Clk = 1'b0;
  logic        Reset, En;
  logic [1:0]  Op;
  logic [2:0]  WAddr, RAddrA, RAddrB;
  logic [15:0] D;
  logic [15:0] QA, QB, QA2, QB2;
  logic        Wrap, Wrap2;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] m  [8];
  logic [15:0] m2 [8];
  logic        mw, mw2;
  bit          valid = 0;

  always #5 Clk = ~Clk;

  mu0_regfile dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Op(Op), .WAddr(WAddr),
    .D(D), .RAddrA(RAddrA), .RAddrB(RAddrB),
    .QA(QA), .QB(QB), .Wrap(Wrap)
  );

  mu0_regfile #(.RESET_VAL(16'h0100)) dut2 (
    .Clk(Clk), .Reset(Reset), .En(En), .Op(Op), .WAddr(WAddr),
    .D(D), .RAddrA(RAddrA), .RAddrB(RAddrB),
    .QA(QA2), .QB(QB2), .Wrap(Wrap2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read: stored model value, plus pending write if forwarding is built.
  function automatic logic [15:0] rd(input bit sec, input logic [2:0] a);
    logic [15:0] v;
    v = sec ? m2[a] : m[a];
`ifdef MU0_REGFILE_BYPASS_EN
    if (Reset === 1'b1 && En === 1'b1 && Op != 2'd0 && a == WAddr) begin
      case (Op)
        2'd1: v = D;
        2'd2: v = v + 16'd1;
        default: v = 16'd0;
      endcase
    end
`endif
    return v;
  endfunction

  task automatic model_edge();
    if (!Reset) begin
      for (int i = 0; i < 8; i++) begin
        m[i]  = 16'h0000;
        m2[i] = 16'h0100;
      end
      mw = 0; mw2 = 0;
      valid = 1;
    end else begin
      mw = 0; mw2 = 0;
      if (En) begin
        case (Op)
          2'd1: begin m[WAddr] = D; m2[WAddr] = D; end
          2'd2: begin
            mw  = (m[WAddr]  == 16'hFFFF);
            mw2 = (m2[WAddr] == 16'hFFFF);
            m[WAddr]  = m[WAddr] + 16'd1;
            m2[WAddr] = m2[WAddr] + 16'd1;
          end
          2'd3: begin m[WAddr] = 16'd0; m2[WAddr] = 16'd0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] o,
                      input logic [2:0] wa, input logic [15:0] dd,
                      input logic [2:0] ra, input logic [2:0] rb);
    Reset = r; En = e; Op = o; WAddr = wa; D = dd;
    RAddrA = ra; RAddrB = rb;
    #1;
    if (valid) begin
      chk("pre_qa",  QA,  rd(0, ra));
      chk("pre_qb",  QB,  rd(0, rb));
      chk("pre_qa2", QA2, rd(1, ra));
      chk("pre_qb2", QB2, rd(1, rb));
    end
    @(posedge Clk);
    model_edge();
    #1;
    chk("qa",    QA,  rd(0, ra));
    chk("qb",    QB,  rd(0, rb));
    chk("qa2",   QA2, rd(1, ra));
    chk("qb2",   QB2, rd(1, rb));
    chk("wrap",  {15'd0, Wrap},  {15'd0, mw});
    chk("wrap2", {15'd0, Wrap2}, {15'd0, mw2});
  endtask

  initial begin
    Reset = 1; En = 0; Op = 0; WAddr = 0; D = 0; RAddrA = 0; RAddrB = 0;
    @(posedge Clk);
    #1;
    // reset while loading all-ones: nothing from that cycle survives
    step(0, 1, 2'd1, 3'd0, 16'hFFFF, 3'd0, 3'd7);
    for (int i = 0; i < 8; i++) step(1, 0, 2'd0, 3'd0, 16'hBEEF, 3'(i), 3'(7 - i));
    // load/hold
    step(1, 1, 2'd1, 3'd3, 16'h1234, 3'd3, 3'd2);
    step(1, 0, 2'd1, 3'd3, 16'hBEEF, 3'd3, 3'd4);
    step(1, 0, 2'd1, 3'd3, 16'hBEEF, 3'd3, 3'd0);
    for (int i = 0; i < 8; i++) step(1, 1, 2'd0, 3'(i), 16'hBEEF, 3'(i), 3'd3);
    // increment wrap
    step(1, 1, 2'd1, 3'd5, 16'hFFFE, 3'd5, 3'd5);
    step(1, 1, 2'd2, 3'd5, 16'h0000, 3'd5, 3'd5);
    step(1, 1, 2'd2, 3'd5, 16'h0000, 3'd5, 3'd5);
    step(1, 0, 2'd2, 3'd5, 16'h0000, 3'd5, 3'd5);
    // clear and dual read
    step(1, 1, 2'd1, 3'd1, 16'h00AA, 3'd1, 3'd2);
    step(1, 1, 2'd1, 3'd2, 16'h0055, 3'd1, 3'd2);
    step(1, 1, 2'd3, 3'd1, 16'h0000, 3'd1, 3'd2);
    // reset mid-operation on a wrapping increment
    step(1, 1, 2'd1, 3'd5, 16'hFFFF, 3'd5, 3'd1);
    step(0, 1, 2'd2, 3'd5, 16'h0000, 3'd5, 3'd2);
    for (int i = 0; i < 8; i++) step(1, 0, 2'd0, 3'd0, 16'h0, 3'(i), 3'(i));
    // write-through visibility
    step(1, 1, 2'd1, 3'd4, 16'hCAFE, 3'd4, 3'd4);
    step(1, 1, 2'd2, 3'd4, 16'h0000, 3'd4, 3'd0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic r;
      logic [15:0] dd;
      r = ($urandom_range(0, 29) != 0);
      case ($urandom_range(0, 3))
        0: dd = 16'hFFFF;
        1: dd = 16'hFFFE;
        default: dd = 16'($urandom);
      endcase
      step(r, 1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), dd,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
